// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer.
// Drives one-cycle datapath enables, counts retired instructions, halts on HALT opcodes or memory timeout.
module cpu_sequencer #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [1:0]       category,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             branch_cond,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             alu_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [1:0]       cat_q;
  logic             is_store_q, is_jump_q;
  logic             retire, timeout_hit;
  logic             fault_q;
  logic [CNT_W-1:0] count_q;

  // Memory handshake: a request is held high every cycle of FETCH/MEM; the access
  // completes in the cycle the matching ready is high while the request is high.
  always_comb begin
    state_d     = state_q;
    wait_d      = 8'd0;
    retire      = 1'b0;
    timeout_hit = 1'b0;
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    alu_en      = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        state_d = (category == 2'b11) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        case (cat_q)
          2'b00: state_d = S_WB;
          2'b01: state_d = S_MEM;
          2'b10: begin
            pc_load = is_jump_q | branch_cond;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store_q;
        if (dmem_ready) begin
          if (is_store_q) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_q     <= 8'd0;
      cat_q      <= 2'b00;
      is_store_q <= 1'b0;
      is_jump_q  <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_DECODE) begin
        cat_q      <= category;
        is_store_q <= (opcode == 4'd4);
        is_jump_q  <= (opcode == 4'd7);
      end
      if (retire)      count_q <= count_q + 1'b1;
      if (timeout_hit) fault_q <= 1'b1;
    end
  end

  assign halted        = (state_q == S_HALT);
  assign fault         = fault_q;
  assign state         = state_q;
  assign retired_count = count_q;

endmodule
